mult_4bit_seq: RTL

- Sequential shift-and-add 4x4 unsigned multiplier that sits directly around adder_4bit: it drives the adder's operand inputs (a, b, c_in, sm) and consumes its sum and carry (s, c_out) every cycle.
- Operands arrive on a valid/ready input handshake.
- The 8-bit product leaves on a valid/ready output handshake.
- It is the first multi-cycle arithmetic block built on the existing combinational adder.

---
 rtl/mult_4bit_seq_pkg.sv | 21 ++
 rtl/adder_4bit.sv | 21 ++
 rtl/mult_4bit_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mult_4bit_seq_pkg.sv
// Shared definitions for the sequential arithmetic blocks: state encodings,
// operand/product widths and the shift-and-add accumulator layout.
package mult_4bit_seq_pkg;

    localparam int MULT_WIDTH  = 4;
    localparam int MULT_PROD_W = 2 * MULT_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // hi holds the running partial sum, lo the unconsumed multiplier bits
    // that are progressively replaced by low product bits.
    typedef struct packed {
        logic [MULT_WIDTH-1:0] hi;
        logic [MULT_WIDTH-1:0] lo;
    } acc_t;

endpackage

// File: rtl/adder_4bit.sv
// 4-bit ripple adder/subtractor: sm=0 adds a+b+c_in, sm=1 computes a-b.
// Latency: combinational. Backpressure: none.
// Carry out is the unsigned carry of the full 5-bit sum.
module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    input  logic       sm,
    output logic [3:0] s,
    output logic       c_out
);

    logic [3:0] b_eff;
    logic       cin_eff;

    assign b_eff   = b ^ {4{sm}};
    assign cin_eff = c_in ^ sm;

    assign {c_out, s} = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin_eff};

endmodule

// File: rtl/mult_4bit_seq.sv
// Shift-and-add 4x4 unsigned multiplier around adder_4bit (MULT_EARLY_EXIT_EN ends CALC early).
// Latency: product valid WIDTH edges after accept (fewer with early exit).
// Backpressure: DONE holds the product until out_ready; no accept until then.
module mult_4bit_seq
    import mult_4bit_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    generate
        if (WIDTH != MULT_WIDTH) begin : g_width_chk
            $error("mult_4bit_seq: WIDTH must be 4 to match adder_4bit");
        end
        if ((1 << CNT_W) <= WIDTH) begin : g_cnt_chk
            $error("mult_4bit_seq: CNT_W too narrow for WIDTH");
        end
    endgenerate

    state_t              state;
    state_t              state_nxt;
    acc_t                acc;
    logic [WIDTH-1:0]    mcand;
    logic [CNT_W-1:0]    cnt;
    logic [2*WIDTH-1:0]  product_q;

    logic [WIDTH-1:0]    add_b;
    logic [WIDTH-1:0]    add_s;
    logic                add_co;
    logic [2*WIDTH-1:0]  step_val;
    logic [2*WIDTH-1:0]  step_prod;
    logic                last_step;

    // The adder always adds; a skipped step adds zero so carry is naturally 0.
    assign add_b = acc.lo[0] ? mcand : '0;

    adder_4bit u_adder (
        .a     (acc.hi),
        .b     (add_b),
        .c_in  (1'b0),
        .sm    (1'b0),
        .s     (add_s),
        .c_out (add_co)
    );

    assign step_val = {add_co, add_s, acc.lo[WIDTH-1:1]};

`ifdef MULT_EARLY_EXIT_EN
    logic [CNT_W-1:0] align_sh;
    logic             rest_zero;

    // Multiplier bits still waiting sit in acc.lo[align_sh:1].
    always_comb begin
        align_sh  = CNT_W'(WIDTH - 1) - cnt;
        rest_zero = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            if ((i <= int'(align_sh)) && acc.lo[i]) begin
                rest_zero = 1'b0;
            end
        end
    end

    assign last_step = rest_zero;
    assign step_prod = step_val >> align_sh;
`else
    assign last_step = (cnt == CNT_W'(WIDTH - 1));
    assign step_prod = step_val;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = CALC;
            CALC:    if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand     <= '0;
            acc       <= '0;
            cnt       <= '0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= a_in;
                        acc.hi <= '0;
                        acc.lo <= b_in;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    acc <= step_val;
                    cnt <= cnt + CNT_W'(1);
                    if (last_step) begin
                        product_q <= step_prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == CALC);
    assign out_valid = (state == DONE);
    assign product   = product_q;

endmodule
